x_uart_cmd_ctrl: RTL and testbench

Command sequencer that sits directly behind the x_uart_rx byte receiver. It frames the received byte stream into write, read and start commands and drives a register-bus write/read interface. Read responses are handed to a UART TX path through a valid/ready handshake. It is the single host-control point for the delay-line design.

---
 rtl/x_uart_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_x_uart_cmd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_uart_cmd_ctrl.sv
// Host command sequencer behind x_uart_rx: frames W/R/S byte packets into
// register-bus writes, reads and start pulses, and returns read data to TX.
module x_uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT = 100000,
    parameter logic [7:0]  OP_WR   = 8'h57,
    parameter logic [7:0]  OP_RD   = 8'h52,
    parameter logic [7:0]  OP_ST   = 8'h53
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_wr_valid,
    output logic [7:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_rd_req,
    output logic [7:0] o_rd_addr,
    input  logic       i_rd_valid,
    input  logic [7:0] i_rd_data,
    output logic       o_start,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_err
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_RD_WAIT = 3'd3,
        S_TX      = 3'd4
    } state_t;

    state_t           state;
    logic             is_rd;
    logic [7:0]       addr_q;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;

    // Idle-gap limit reached in the current cycle
    assign cnt_last = (cnt == CNT_W'(TIMEOUT - 1));

    // Packet framing FSM with registered strobes, bus fields and TX handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            is_rd      <= 1'b0;
            addr_q     <= 8'h00;
            cnt        <= '0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= 8'h00;
            o_wr_data  <= 8'h00;
            o_rd_req   <= 1'b0;
            o_rd_addr  <= 8'h00;
            o_start    <= 1'b0;
            o_tx_valid <= 1'b0;
            o_tx_data  <= 8'h00;
            o_busy     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_wr_valid <= 1'b0;
            o_rd_req   <= 1'b0;
            o_start    <= 1'b0;
            o_err      <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (i_valid) begin
                        if (i_data == OP_WR) begin
                            state  <= S_ADDR;
                            is_rd  <= 1'b0;
                            o_busy <= 1'b1;
                        end else if (i_data == OP_RD) begin
                            state  <= S_ADDR;
                            is_rd  <= 1'b1;
                            o_busy <= 1'b1;
                        end else if (i_data == OP_ST) begin
                            o_start <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end

                S_ADDR: begin
                    if (i_valid) begin
                        cnt <= '0;
                        if (is_rd) begin
                            o_rd_addr <= i_data;
                            o_rd_req  <= 1'b1;
                            state     <= S_RD_WAIT;
                        end else begin
                            addr_q <= i_data;
                            state  <= S_DATA;
                        end
                    end else if (cnt_last) begin
                        cnt    <= '0;
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (i_valid) begin
                        cnt        <= '0;
                        o_wr_valid <= 1'b1;
                        o_wr_addr  <= addr_q;
                        o_wr_data  <= i_data;
                        state      <= S_IDLE;
                        o_busy     <= 1'b0;
                    end else if (cnt_last) begin
                        cnt    <= '0;
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_RD_WAIT: begin
                    // A stray host byte is flagged but never disturbs the read
                    if (i_valid) begin
                        o_err <= 1'b1;
                    end
                    if (i_rd_valid) begin
                        cnt        <= '0;
                        o_tx_data  <= i_rd_data;
                        o_tx_valid <= 1'b1;
                        state      <= S_TX;
                    end else if (i_valid) begin
                        cnt <= '0;
                    end else if (cnt_last) begin
                        cnt    <= '0;
                        state  <= S_IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_TX: begin
                    cnt <= '0;
                    if (i_valid) begin
                        o_err <= 1'b1;
                    end
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        state      <= S_IDLE;
                        o_busy     <= 1'b0;
                    end
                end

                default: begin
                    cnt        <= '0;
                    state      <= S_IDLE;
                    o_busy     <= 1'b0;
                    o_tx_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_uart_cmd_ctrl.sv
// Scoreboard bench for x_uart_cmd_ctrl: expected strobes and TX bytes are
// queued with their due cycle when stimulus is issued; a monitor compares.
module tb_x_uart_cmd_ctrl;

    localparam int unsigned TO = 16;
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;
    localparam logic [7:0] OP_ST = 8'h53;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_ST = 2;
    localparam int K_ER = 3;

    logic       i_clk;
    logic       i_rst;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_wr_valid;
    logic [7:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_rd_req;
    logic [7:0] o_rd_addr;
    logic       i_rd_valid;
    logic [7:0] i_rd_data;
    logic       o_start;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       i_tx_ready;
    logic       o_busy;
    logic       o_err;

    x_uart_cmd_ctrl #(
        .TIMEOUT(TO), .OP_WR(OP_WR), .OP_RD(OP_RD), .OP_ST(OP_ST)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
        .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
        .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr),
        .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .o_start(o_start),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_err(o_err)
    );

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [7:0]  d;
        int unsigned cyc;
    } ev_t;

    typedef struct {
        logic [7:0]  d;
        int unsigned len;
    } tx_t;

    ev_t exp_q[$];
    tx_t tx_q[$];

    int unsigned cyc;
    int          checks;
    int          errors;
    logic [7:0]  exp_wr_a, exp_wr_d, exp_rd_a;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] a, input logic [7:0] d,
                             input int unsigned c);
        ev_t e;
        e.kind = k; e.a = a; e.d = d; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // One cycle of input drive, applied just after the rising edge
    task automatic tick(input logic v, input logic [7:0] d, input logic rv,
                        input logic [7:0] rdd, input logic rdy);
        @(posedge i_clk); #1;
        i_valid = v; i_data = d; i_rd_valid = rv; i_rd_data = rdd; i_tx_ready = rdy;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic hold_check();
        chk("wr_addr_hold", 32'(o_wr_addr), 32'(exp_wr_a));
        chk("wr_data_hold", 32'(o_wr_data), 32'(exp_wr_d));
        chk("rd_addr_hold", 32'(o_rd_addr), 32'(exp_rd_a));
    endtask

    // Opcode, address, data with gaps in cycles between strobes (<= TO accepted)
    task automatic write_txn(input logic [7:0] a, input logic [7:0] d,
                             input int g1, input int g2);
        send(OP_WR);
        idle(g1 - 1);
        send(a);
        chk("busy_in_packet", 32'(o_busy), 32'd1);
        idle(g2 - 1);
        send(d);
        expect_ev(K_WR, a, d, cyc + 1);
        exp_wr_a = a; exp_wr_d = d;
        idle(1);
        chk("busy_after_write", 32'(o_busy), 32'd0);
    endtask

    // Read: response lat cycles after the rd_req cycle, bp cycles of backpressure,
    // optional stray byte during RD_WAIT (at offset k) and during TX (offset j)
    task automatic read_txn(input logic [7:0] a, input logic [7:0] d, input int lat,
                            input int bp, input bit inj, input int k,
                            input bit itx, input int j);
        logic [7:0] sb;
        tx_t t;
        send(OP_RD);
        send(a);
        expect_ev(K_RD, a, 8'h00, cyc + 1);
        exp_rd_a = a;
        sb = 8'($urandom);
        for (int c = 0; c <= lat; c++) begin
            tick(inj && (c == k), sb, c == lat, d, 1'b0);
            if (inj && (c == k)) expect_ev(K_ER, 8'h00, 8'h00, cyc + 1);
        end
        t.d = d; t.len = 32'(bp + 1);
        tx_q.push_back(t);
        for (int c = 0; c <= bp; c++) begin
            tick(itx && (c == j), sb, 1'b0, 8'h00, c == bp);
            if (itx && (c == j)) expect_ev(K_ER, 8'h00, 8'h00, cyc + 1);
        end
        idle(1);
        chk("tx_valid_dropped", 32'(o_tx_valid), 32'd0);
        chk("busy_after_read", 32'(o_busy), 32'd0);
    endtask

    task automatic single_byte(input logic [7:0] b);
        send(b);
        expect_ev((b == OP_ST) ? K_ST : K_ER, 8'h00, 8'h00, cyc + 1);
    endtask

    // Packet abandoned after n_bytes (1: opcode only, 2: opcode + address)
    task automatic timeout_txn(input logic [7:0] op, input int n_bytes, input logic [7:0] a);
        send(op);
        if (n_bytes == 2) begin
            send(a);
            if (op == OP_RD) begin
                expect_ev(K_RD, a, 8'h00, cyc + 1);
                exp_rd_a = a;
            end
        end
        expect_ev(K_ER, 8'h00, 8'h00, cyc + TO + 1);
        idle(TO + 2);
        chk("busy_after_timeout", 32'(o_busy), 32'd0);
    endtask

    // Monitor: strobes against the event queue, TX bytes against the TX queue
    logic        tx_busy;
    logic [7:0]  tx_hold;
    int unsigned tx_len;

    task automatic take(input int k);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_strobe: actual kind=%0d at cycle %0d required none", k, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc ||
                (k == K_WR && (o_wr_addr != e.a || o_wr_data != e.d)) ||
                (k == K_RD && o_rd_addr != e.a)) begin
                errors++;
                $display("FAIL strobe: actual kind=%0d cyc=%0d wa=%0h wd=%0h ra=%0h required kind=%0d cyc=%0d a=%0h d=%0h",
                         k, cyc, o_wr_addr, o_wr_data, o_rd_addr, e.kind, e.cyc, e.a, e.d);
            end
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (32'(o_wr_valid) + 32'(o_rd_req) + 32'(o_start) > 1)
                chk("strobe_onehot", 32'(o_wr_valid) + 32'(o_rd_req) + 32'(o_start), 32'd1);
            if (o_wr_valid) take(K_WR);
            if (o_rd_req)   take(K_RD);
            if (o_start)    take(K_ST);
            if (o_err)      take(K_ER);
            if (o_tx_valid) begin
                if (!tx_busy) begin
                    tx_hold = o_tx_data;
                    tx_len  = 0;
                end
                tx_len++;
                chk("tx_data_stable", 32'(o_tx_data), 32'(tx_hold));
                if (i_tx_ready) begin
                    if (tx_q.size() == 0) begin
                        chk("unexpected_tx", 32'(o_tx_data), 32'hFFFF_FFFF);
                    end else begin
                        tx_t t;
                        t = tx_q.pop_front();
                        chk("tx_data", 32'(o_tx_data), 32'(t.d));
                        chk("tx_valid_cycles", tx_len, t.len);
                    end
                end
            end
            tx_busy = o_tx_valid && !i_tx_ready;
        end else begin
            tx_busy = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        int         sel;
        checks = 0; errors = 0; cyc = 0;
        tx_busy = 1'b0; tx_hold = 8'h00; tx_len = 0;
        exp_wr_a = 8'h00; exp_wr_d = 8'h00; exp_rd_a = 8'h00;
        i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00;
        i_rd_valid = 1'b0; i_rd_data = 8'h00; i_tx_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_flags", 32'({o_wr_valid, o_rd_req, o_start, o_tx_valid, o_busy, o_err}), 32'd0);
        chk("reset_fields", {o_wr_addr, o_wr_data, o_rd_addr, o_tx_data}, 32'd0);
        i_rst = 1'b0;
        idle(2);

        // Directed cases
        write_txn(8'h3A, 8'hC5, 10, 10);
        hold_check();
        idle(2);
        read_txn(8'h07, 8'hA9, 5, 20, 1'b0, 0, 1'b0, 0);
        idle(2);
        single_byte(8'h53);
        idle(2);
        single_byte(8'h41);
        idle(1);
        chk("busy_after_illegal", 32'(o_busy), 32'd0);
        timeout_txn(OP_WR, 1, 8'h00);
        single_byte(OP_ST);
        idle(2);
        write_txn(8'h5E, 8'h12, TO, TO);
        idle(2);
        timeout_txn(OP_WR, 2, 8'h33);
        timeout_txn(OP_RD, 2, 8'h44);
        // Late read data after a read timeout must be ignored
        tick(1'b0, 8'h00, 1'b1, 8'hEE, 1'b0);
        idle(3);
        // Back-to-back packets
        send(OP_WR); send(8'h81); send(8'h7F);
        expect_ev(K_WR, 8'h81, 8'h7F, cyc + 1);
        exp_wr_a = 8'h81; exp_wr_d = 8'h7F;
        single_byte(OP_ST);
        idle(2);
        hold_check();
        // Reset in the middle of a packet
        send(OP_WR); send(8'h10);
        @(posedge i_clk); #1;
        i_rst = 1'b1; i_valid = 1'b0; i_rd_valid = 1'b0; i_tx_ready = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("midrst_flags", 32'({o_wr_valid, o_rd_req, o_start, o_tx_valid, o_busy, o_err}), 32'd0);
        exp_wr_a = 8'h00; exp_wr_d = 8'h00; exp_rd_a = 8'h00;
        hold_check();
        single_byte(8'h22);
        idle(2);
        // Stray byte while the read is outstanding, then during TX
        read_txn(8'h01, 8'h6C, 5, 3, 1'b1, 2, 1'b0, 0);
        idle(2);
        read_txn(8'h02, 8'h3D, 2, 4, 1'b1, 2, 1'b1, 1);
        idle(2);

        // Randomized packet mix
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: write_txn(8'($urandom), 8'($urandom),
                                int'($urandom_range(1, TO)), int'($urandom_range(1, TO)));
                2: begin
                    int lat, bp;
                    lat = int'($urandom_range(0, 8));
                    bp  = int'($urandom_range(0, 6));
                    read_txn(8'($urandom), 8'($urandom), lat, bp,
                             1'($urandom_range(0, 1)), int'($urandom_range(0, lat)),
                             1'($urandom_range(0, 1)), int'($urandom_range(0, bp)));
                end
                3: begin
                    b = 8'($urandom);
                    while (b == OP_WR || b == OP_RD) b = 8'($urandom);
                    single_byte(b);
                end
                4: timeout_txn(($urandom_range(0, 1) == 1) ? OP_RD : OP_WR,
                               int'($urandom_range(1, 2)), 8'($urandom));
                default: timeout_txn(OP_WR, 2, 8'($urandom));
            endcase
            idle(int'($urandom_range(1, 3)));
            hold_check();
        end

        idle(TO + 8);
        chk("events_left", 32'(exp_q.size()), 32'd0);
        chk("tx_left", 32'(tx_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
